// File: rtl/fetch_queue.sv
// fetch_queue: 4-entry in-order instruction queue between fetch and decode
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_PC,
  input  logic [31:0] IN_INSTRUCTION,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [31:0] OUT_PC_PLUS4,
  output logic [2:0]  COUNT
);
  logic [31:0] pc_q [4];
  logic [31:0] pc_d [4];
  logic [31:0] ins_q [4];
  logic [31:0] ins_d [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic push, pop;
  // Handshakes are blocked during a flush; the head reads as zero when empty
  always_comb begin
    IN_READY = cnt_q < 3'(DEPTH) && !FLUSH;
    OUT_VALID = cnt_q != 3'd0 && !FLUSH;
    push = IN_VALID && IN_READY;
    pop = OUT_VALID && OUT_READY;
    OUT_PC = cnt_q != 3'd0 ? pc_q[rp_q] : 32'd0;
    OUT_INSTRUCTION = cnt_q != 3'd0 ? ins_q[rp_q] : 32'd0;
    OUT_PC_PLUS4 = OUT_PC + 32'd4;
    COUNT = cnt_q;
  end
  // Next state: write at WP on push, advance RP on pop, flush rewinds everything
  always_comb begin
    pc_d = pc_q;
    ins_d = ins_q;
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) begin
      pc_d[wp_q] = IN_PC;
      ins_d[wp_q] = IN_INSTRUCTION;
      wp_d = wp_q + 2'd1;
    end
    if (pop) rp_d = rp_q + 2'd1;
    cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
    if (FLUSH) begin
      wp_d = '0;
      rp_d = '0;
      cnt_d = '0;
    end
  end
  // State registers with asynchronous reset that also clears storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= '{default: '0};
      ins_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      ins_q <= ins_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
  logic        CLK = 0;
  logic        RST = 1;
  logic        IN_VALID = 0;
  logic        IN_READY;
  logic [31:0] IN_PC = 0;
  logic [31:0] IN_INSTRUCTION = 0;
  logic        FLUSH = 0;
  logic        OUT_VALID;
  logic        OUT_READY = 0;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_INSTRUCTION;
  logic [31:0] OUT_PC_PLUS4;
  logic [2:0]  COUNT;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];
  int pass_cnt = 0;
  int total = 0;

  fetch_queue dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PC(IN_PC), .IN_INSTRUCTION(IN_INSTRUCTION), .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
    .OUT_INSTRUCTION(OUT_INSTRUCTION), .OUT_PC_PLUS4(OUT_PC_PLUS4), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: every completed pop must deliver the oldest outstanding entry
  always @(negedge CLK) begin
    if (!RST && OUT_VALID === 1'b1 && OUT_READY) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL pop_empty: got pop of pc %h expected no pop at %0t", OUT_PC, $time);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_pc", OUT_PC, e.pc);
        chk("pop_ins", OUT_INSTRUCTION, e.ins);
        chk("pop_pc4", OUT_PC_PLUS4, e.pc + 32'd4);
      end
    end
  end

  // One cycle: drive at posedge+1, check at posedge+2, update model at next posedge
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    logic acc;
    IN_VALID = iv;
    IN_PC = pc;
    IN_INSTRUCTION = ins;
    OUT_READY = ordy;
    FLUSH = fl;
    #1;
    chk("in_ready", 32'(IN_READY), 32'(sb.size() < 4 && !fl));
    chk("out_valid", 32'(OUT_VALID), 32'(sb.size() != 0 && !fl));
    chk("count", 32'(COUNT), 32'(sb.size()));
    if (sb.size() == 0) begin
      chk("empty_pc", OUT_PC, 32'd0);
      chk("empty_pc4", OUT_PC_PLUS4, 32'd4);
    end else begin
      chk("head_pc", OUT_PC, sb[0].pc);
      chk("head_ins", OUT_INSTRUCTION, sb[0].ins);
      chk("head_pc4", OUT_PC_PLUS4, sb[0].pc + 32'd4);
    end
    acc = iv && sb.size() < 4 && !fl;
    @(posedge CLK);
    if (fl) sb.delete();
    else if (acc) sb.push_back({pc, ins});
    #1;
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_pc", OUT_PC, 32'd0);
    chk("rst_ins", OUT_INSTRUCTION, 32'd0);
    chk("rst_pc4", OUT_PC_PLUS4, 32'd4);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 0;
    // three pushes with no consumer
    for (int i = 0; i < 3; i++) step(1, 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // five offers into four slots, then drain
    for (int i = 0; i < 5; i++) step(1, 32'(i * 4), 32'h2000 + 32'(i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // streaming push and pop, pointers wrap
    for (int i = 0; i < 10; i++) step(1, 32'h100 + 32'(i * 4), 32'h3000 + 32'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // flush at three entries with both sides offering
    for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(i * 4), 32'h4000 + 32'(i), 0, 0);
    step(1, 32'h300, 32'h5000, 1, 1);
    step(0, 0, 0, 1, 0);
    // wrapping PC+4
    step(1, 32'hFFFFFFFC, 32'h2008000A, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // asynchronous reset between edges with two entries held
    step(1, 32'h10, 32'h6000, 0, 0);
    step(1, 32'h14, 32'h6001, 0, 0);
    IN_VALID = 0;
    #2 RST = 1;
    #1;
    chk("arst_count", 32'(COUNT), 32'd0);
    chk("arst_out_valid", 32'(OUT_VALID), 32'd0);
    sb.delete();
    @(posedge CLK);
    #1 RST = 0;
    step(1, 32'h40, 32'h7000, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom & 32'hFFFFFFFC, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    chk("drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
